// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants and helpers for fetch, decode and control
package mips_pkg;

    // PC loaded by reset; also the first fetch address after reset release.
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    // Next-PC select codes driven by the ID-stage decoder.
    localparam int          NPC_OP_W = 2;
    localparam logic [1:0]  NPC_SEQ  = 2'b00;
    localparam logic [1:0]  NPC_BR   = 2'b01;
    localparam logic [1:0]  NPC_J    = 2'b10;
    localparam logic [1:0]  NPC_JR   = 2'b11;

    // Sign-extended, word-scaled branch offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// rtl/fetch_unit_npc.sv - combinational next-PC select and address adders
module npc
    import mips_pkg::*;
#(
    parameter int NPC_W = 2
) (
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_id_pc,
    input  logic [NPC_W-1:0] i_npc_op,
    input  logic             i_br_true,
    input  logic [15:0]      i_imm16,
    input  logic [25:0]      i_instr_index,
    input  logic [31:0]      i_jr_target,
    output logic [31:0]      o_npc
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    // All sums wrap modulo 2^32; there is intentionally no overflow flag.
    assign w_pc4       = i_pc + 32'd4;
    // Branch target is relative to the branch's own slot (id_pc), not the fetch PC.
    assign w_br_target = i_id_pc + 32'd4 + br_offset(i_imm16);
    assign w_j_target  = {i_id_pc[31:28], i_instr_index, 2'b00};

    // Select the next PC; an untaken branch falls through exactly like seq.
    always_comb begin
        o_npc = w_pc4;
        if (i_npc_op == NPC_W'(NPC_BR)) begin
            o_npc = i_br_true ? w_br_target : w_pc4;
        end else if (i_npc_op == NPC_W'(NPC_J)) begin
            o_npc = w_j_target;
        end else if (i_npc_op == NPC_W'(NPC_JR)) begin
            // jr targets are passed through unaligned; imem sees whatever rs held.
            o_npc = i_jr_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC register, next-PC selection and IF/ID register
module fetch_unit #(
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
    parameter int          NPC_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [NPC_W-1:0] npc_op,
    input  logic             br_true,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      jr_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc8
);

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] w_npc;

    npc #(
        .NPC_W (NPC_W)
    ) u_npc (
        .i_pc          (r_pc),
        .i_id_pc       (r_id_pc),
        .i_npc_op      (npc_op),
        .i_br_true     (br_true),
        .i_imm16       (imm16),
        .i_instr_index (instr_index),
        .i_jr_target   (jr_target),
        .o_npc         (w_npc)
    );

    // PC and IF/ID advance together; a stall freezes both, so a redirect decoded
    // during the stall is simply re-evaluated once the stall lifts. The slot
    // fetched alongside a taken redirect enters IF/ID normally (delay slot).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= PC_RESET;
            r_id_instr <= 32'h0;
            r_id_pc    <= PC_RESET;
        end else if (!stall) begin
            r_pc       <= w_npc;
            r_id_instr <= imem_rdata;
            r_id_pc    <= r_pc;
        end
    end

    assign imem_addr = r_pc;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_pc8    = r_id_pc + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [1:0] OP_SEQ = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_J   = 2'b10;
    localparam logic [1:0] OP_JR  = 2'b11;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] id_pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_true;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;

    fetch_unit #(
        .PC_RESET (32'h0000_3000),
        .NPC_W    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_op      (npc_op),
        .br_true     (br_true),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc8      (id_pc8)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [1:0] op, input logic br,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] jr);
        logic [31:0] off;
        off = {{16{imm[15]}}, imm} << 2;
        case (op)
            OP_BR:   return br ? (m_id_pc + 32'd4 + off) : (m_pc + 32'd4);
            OP_J:    return {m_id_pc[31:28], idx, 2'b00};
            OP_JR:   return jr;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    task automatic model_reset();
        m_pc       = RST_PC;
        m_id_pc    = RST_PC;
        m_id_instr = 32'h0;
    endtask

    // Called at a negative edge: drive, predict, cross one rising edge, compare.
    task automatic step(input string tag, input logic st, input logic [1:0] op,
                        input logic br, input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] jr);
        exp_t e;
        logic [31:0] nxt;
        stall       = st;
        npc_op      = op;
        br_true     = br;
        imm16       = imm;
        instr_index = idx;
        jr_target   = jr;
        if (!st) begin
            nxt        = model_npc(op, br, imm, idx, jr);
            m_id_instr = mem(m_pc);
            m_id_pc    = m_pc;
            m_pc       = nxt;
        end
        e.pc    = m_pc;
        e.instr = m_id_instr;
        e.id_pc = m_id_pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},       imem_addr, e.pc);
        chk({tag, ".id_instr"}, id_instr,  e.instr);
        chk({tag, ".id_pc"},    id_pc,     e.id_pc);
        chk({tag, ".id_pc8"},   id_pc8,    e.id_pc + 32'd8);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".pc"},       imem_addr, 32'h0000_3000);
        chk({tag, ".id_instr"}, id_instr,  32'h0);
        chk({tag, ".id_pc"},    id_pc,     32'h0000_3000);
        chk({tag, ".id_pc8"},   id_pc8,    32'h0000_3008);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        npc_op      = OP_SEQ;
        br_true     = 1'b0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        jr_target   = 32'h0;
        model_reset();

        // Asynchronous reset with no clock edge in between.
        #1 reset = 1'b0;
        #2;
        chk_reset_state("rst_async");

        @(negedge clk);
        reset = 1'b1;
        chk("fetch0", imem_addr, 32'h0000_3000);
        step("seq1", 1'b0, OP_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("fetch1", imem_addr, 32'h0000_3004);
        step("seq2", 1'b0, OP_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("fetch2", imem_addr, 32'h0000_3008);

        // beq taken from id_pc=0x3004 with offset -1 word: delay slot 0x3008 enters ID.
        chk("beq.id_pc_pre", id_pc, 32'h0000_3004);
        step("beq", 1'b0, OP_BR, 1'b1, 16'hFFFF, 26'h0, 32'h0);
        chk("beq.target", imem_addr, 32'h0000_3004);
        chk("beq.slot",   id_pc,     32'h0000_3008);

        // Untaken branch behaves as sequential.
        step("bnt", 1'b0, OP_BR, 1'b0, 16'h0010, 26'h0, 32'h0);
        chk("bnt.pc", imem_addr, 32'h0000_3008);

        // Taken branch held off by a 3-cycle stall, then redirects.
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, OP_BR, 1'b1, 16'h0004, 26'h0, 32'h0);
            chk("stall.pc", imem_addr, 32'h0000_3008);
        end
        step("unstall", 1'b0, OP_BR, 1'b1, 16'h0004, 26'h0, 32'h0);
        chk("unstall.pc", imem_addr, 32'h0000_3018);

        // Reset mid-run, with a stall and a redirect pending.
        stall   = 1'b1;
        npc_op  = OP_BR;
        br_true = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_state("rst_held");
        @(negedge clk);
        reset   = 1'b1;
        stall   = 1'b0;
        npc_op  = OP_SEQ;
        br_true = 1'b0;
        chk("refetch0", imem_addr, 32'h0000_3000);
        step("rseq1", 1'b0, OP_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("refetch1", imem_addr, 32'h0000_3004);
        step("rseq2", 1'b0, OP_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("refetch2", imem_addr, 32'h0000_3008);
        for (int i = 0; i < 3; i++) begin
            step("rseq", 1'b0, OP_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        end

        // jal from id_pc=0x3010, then jr back to the link value.
        chk("jal.id_pc",  id_pc,  32'h0000_3010);
        chk("jal.id_pc8", id_pc8, 32'h0000_3018);
        step("jal", 1'b0, OP_J, 1'b0, 16'h0, 26'h000_0C10, 32'h0);
        chk("jal.pc", imem_addr, 32'h0000_3040);
        step("jr", 1'b0, OP_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3018);
        chk("jr.pc", imem_addr, 32'h0000_3018);

        // Misaligned jr target is passed straight through.
        step("jr_odd", 1'b0, OP_JR, 1'b0, 16'h0, 26'h0, 32'h0000_3001);
        chk("jr_odd.pc", imem_addr, 32'h0000_3001);

        // Sequential fetch wraps silently at the top of the address space.
        step("jr_top", 1'b0, OP_JR, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step("wrap", 1'b0, OP_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("wrap.pc",    imem_addr, 32'h0000_0000);
        chk("wrap.id_pc", id_pc,     32'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, the PC value loaded on reset.
REQ-002 SHALL have parameter NPC_W, default 2, the width of the next-PC select code.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port stall, input, 1, from the hazard unit; 1 freezes PC and the IF/ID register.
REQ-006 SHALL have port npc_op, input, NPC_W: decoded ID-stage control; 00 seq, 01 branch, 10 j/jal, 11 jr.
REQ-007 SHALL have port br_true, input, 1, the ID-stage branch comparator result.
REQ-008 SHALL have port imm16, input, 16, the ID-stage branch offset field.
REQ-009 SHALL have port instr_index, input, 26, the ID-stage j/jal target field.
REQ-010 SHALL have port jr_target, input, 32, the forwarded rs value for jr.
REQ-011 SHALL have port imem_addr, output, 32, the current PC driven to instruction memory.
REQ-012 SHALL have port imem_rdata, input, 32, the combinational instruction read at imem_addr.
REQ-013 SHALL have port id_instr, output, 32, the registered IF/ID instruction.
REQ-014 SHALL have port id_pc, output, 32, the registered IF/ID PC.
REQ-015 SHALL have port id_pc8, output, 32, equal to id_pc+8 (jal link value), derived combinationally from id_pc.

Function
REQ-016 SHALL hold a 32-bit PC register; imem_addr = PC combinationally.
REQ-017 SHALL compute npc each cycle from npc_op and the ID-stage fields.
- seq: PC+4.
- branch: br_true ? id_pc+4+(sext(imm16)<<2) : PC+4.
- j/jal: {id_pc[31:28], instr_index, 2'b00}.
- jr: jr_target.
REQ-018 SHALL perform all additions modulo 2^32; wrap-around is silent and gives no error indication.
REQ-019 SHALL, when stall=0, on each rising edge load PC<=npc, id_instr<=imem_rdata and id_pc<=PC.
REQ-020 SHALL, when stall=1, hold PC, id_instr and id_pc unchanged; a redirect requested in that cycle is ignored, and the held ID instruction re-evaluates it on the next unstalled cycle.
REQ-021 SHALL implement one architectural delay slot: the instruction fetched in the cycle a redirect is taken enters IF/ID normally and is never flushed.
REQ-022 SHALL have a latency of one cycle from PC presentation to id_instr/id_pc valid.
REQ-023 SHALL treat npc_op=01 with br_true=0 exactly as seq.
REQ-024 SHALL, for a branch or jump whose target equals PC, reload the same PC; no special case applies.
REQ-025 SHALL use jr_target as given, with no alignment check, and pass any misalignment to imem_addr.

Reset
REQ-026 SHALL, on reset=0 and regardless of clk, immediately set PC=PC_RESET, id_instr=32'h0 (nop), id_pc=PC_RESET and id_pc8=PC_RESET+8.
REQ-027 SHALL, when reset asserts mid-operation, discard any pending redirect or stall; the first fetch after release is PC_RESET.
REQ-028 SHALL have the deassertion of reset take effect at the next rising edge; the first edge with reset=1 and stall=0 loads PC_RESET+4.

Structure
REQ-029 SHALL place PC_RESET and the NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings in the shared pipeline package (mips_pkg) used by decode and control.
REQ-030 SHALL contain exactly one sub-module, npc, holding the combinational next-PC mux and adders; the PC register and IF/ID register remain in fetch_unit.

Verification
REQ-031 SHALL verify: reset low mid-run -> PC=0x3000, id_instr=0, id_pc=0x3000; release -> fetch sequence 0x3000, 0x3004, 0x3008.
REQ-032 SHALL verify: beq taken with id_pc=0x3004, imm16=0xFFFF, br_true=1 -> delay-slot 0x3008 fetched, then PC=0x3004.
REQ-033 SHALL verify: npc_op=01, br_true=0 -> PC advances by 4 only.
REQ-034 SHALL verify: stall=1 for 3 cycles during a taken branch -> PC, id_instr and id_pc frozen; redirect occurs on the first cycle with stall=0.
REQ-035 SHALL verify: jal with id_pc=0x3010, instr_index=0x0000C10 -> PC=0x0000_3040, id_pc8=0x3018; jr with jr_target=0x3018 -> PC=0x3018.
REQ-036 SHALL verify: PC=0xFFFF_FFFC, seq -> PC=0x0000_0000 with no other effect.
